dual_mem_wb_pipe: RTL and testbench

Back half of the dual-issue not-taken pipeline. It consumes the two EX/MEM slot bundles and performs data-memory access. It also holds the MEM/WB pipeline registers and resolves branch mispredictions. Finally, it returns to the front half everything that half takes as input: write-back bundles, forwarding selects, MEM-stage forward data, and the flush/correction controls.

---
 rtl/dual_pipe_pkg.sv | 19 +
 rtl/dual_mem_wb_pipe_if.sv | 75 +++++++
 rtl/dual_fwd_unit.sv | 42 ++++
 rtl/dual_mem_wb_pipe.sv | 146 ++++++++++++++
 tb/tb_dual_mem_wb_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dual_pipe_pkg.sv
// rtl/dual_pipe_pkg.sv - shared constants for the dual-issue back-half pipeline
//
// Purpose: forwarding one-hot select codes, PC width and the link register
// index shared by the forwarding unit, the bus interface and the top.
package dual_pipe_pkg;

  localparam int PC_W = 10;

  // One-hot forwarding selects; one bit per operand source.
  localparam logic [4:0] FWD_RF   = 5'b00001;
  localparam logic [4:0] FWD_EX1  = 5'b00010;
  localparam logic [4:0] FWD_EX2  = 5'b00100;
  localparam logic [4:0] FWD_MEM1 = 5'b01000;
  localparam logic [4:0] FWD_MEM2 = 5'b10000;

  // Link register written by jal.
  localparam logic [4:0] RA_REG = 5'd31;

endpackage

// File: rtl/dual_mem_wb_pipe_if.sv
// rtl/dual_mem_wb_pipe_if.sv - bus between the front half and the MEM/WB back half
//
// Purpose: carries the two EX/MEM slot bundles, the ID/EX hazard inputs and
// everything returned to the front half (forward selects, MEM forward data,
// redirect/flush controls, MEM/WB registers).
// Modports:
//   master - front half: drives MEM bundles and hazard inputs, reads results
//   slave  - dual_mem_wb_pipe: reads MEM bundles, drives results
interface dual_mem_wb_pipe_if #(
  parameter int PC_W = dual_pipe_pkg::PC_W
);

  // EX/MEM slot bundles
  logic [31:0]     aluRes1_MEM, aluRes2_MEM;
  logic [31:0]     forwardBRes1_MEM, forwardBRes2_MEM;
  logic            MemReadEn1_MEM, MemReadEn2_MEM;
  logic            MemtoReg1_MEM, MemtoReg2_MEM;
  logic            MemWriteEn1_MEM, MemWriteEn2_MEM;
  logic            RegWriteEn1_MEM, RegWriteEn2_MEM;
  logic            jal1_MEM, jal2_MEM;
  logic            taken1_MEM, taken2_MEM;
  logic [4:0]      DestReg1_MEM, DestReg2_MEM;
  logic [PC_W-1:0] return_addr1_MEM, return_addr2_MEM;
  logic [PC_W-1:0] branch_target1_MEM, branch_target2_MEM;

  // ID sources and EX producers
  logic [4:0]      rs1, rt1, rs2, rt2;
  logic [4:0]      DestReg1_EX, DestReg2_EX;
  logic            RegWriteEn1_EX, RegWriteEn2_EX;

  // Returned to the front half
  logic [4:0]      ForwardA_1, ForwardB_1, ForwardA_2, ForwardB_2;
  logic [31:0]     aluRes1_MEM_fwd, aluRes2_MEM_fwd;
  logic            correct_en;
  logic [PC_W-1:0] correction;
  logic            flush_IFID, flush_IDEX;
  logic            regWrite1_WB, regWrite2_WB;
  logic            jal1_WB, jal2_WB;
  logic [4:0]      writeReg1_WB, writeReg2_WB;
  logic [31:0]     writeData1_WB, writeData2_WB;
  logic [31:0]     aluRes1_WB, aluRes2_WB;

  modport master (
    output aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM,
           MemReadEn1_MEM, MemReadEn2_MEM, MemtoReg1_MEM, MemtoReg2_MEM,
           MemWriteEn1_MEM, MemWriteEn2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM,
           jal1_MEM, jal2_MEM, taken1_MEM, taken2_MEM,
           DestReg1_MEM, DestReg2_MEM, return_addr1_MEM, return_addr2_MEM,
           branch_target1_MEM, branch_target2_MEM,
           rs1, rt1, rs2, rt2, DestReg1_EX, DestReg2_EX,
           RegWriteEn1_EX, RegWriteEn2_EX,
    input  ForwardA_1, ForwardB_1, ForwardA_2, ForwardB_2,
           aluRes1_MEM_fwd, aluRes2_MEM_fwd, correct_en, correction,
           flush_IFID, flush_IDEX, regWrite1_WB, regWrite2_WB,
           jal1_WB, jal2_WB, writeReg1_WB, writeReg2_WB,
           writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB
  );

  modport slave (
    input  aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM,
           MemReadEn1_MEM, MemReadEn2_MEM, MemtoReg1_MEM, MemtoReg2_MEM,
           MemWriteEn1_MEM, MemWriteEn2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM,
           jal1_MEM, jal2_MEM, taken1_MEM, taken2_MEM,
           DestReg1_MEM, DestReg2_MEM, return_addr1_MEM, return_addr2_MEM,
           branch_target1_MEM, branch_target2_MEM,
           rs1, rt1, rs2, rt2, DestReg1_EX, DestReg2_EX,
           RegWriteEn1_EX, RegWriteEn2_EX,
    output ForwardA_1, ForwardB_1, ForwardA_2, ForwardB_2,
           aluRes1_MEM_fwd, aluRes2_MEM_fwd, correct_en, correction,
           flush_IFID, flush_IDEX, regWrite1_WB, regWrite2_WB,
           jal1_WB, jal2_WB, writeReg1_WB, writeReg2_WB,
           writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB
  );

endinterface

// File: rtl/dual_fwd_unit.sv
// rtl/dual_fwd_unit.sv - one-hot forward select for a single source operand
//
// Purpose: picks the youngest in-flight producer of src.
// Ports:
//   src                 - ID-stage source register
//   ex{1,2}_dest/_wr    - EX-stage producers
//   mem{1,2}_dest/_wr   - MEM-stage producers
//   squash              - MEM bundle is wrong-path; its producers are ignored
//   sel                 - one-hot select (FWD_* codes)
module dual_fwd_unit
  import dual_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex1_dest,
  input  logic       ex1_wr,
  input  logic [4:0] ex2_dest,
  input  logic       ex2_wr,
  input  logic [4:0] mem1_dest,
  input  logic       mem1_wr,
  input  logic [4:0] mem2_dest,
  input  logic       mem2_wr,
  input  logic       squash,
  output logic [4:0] sel
);

  logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;

  assign hit_ex1  = ex1_wr  && (ex1_dest  != 5'd0) && (ex1_dest  == src);
  assign hit_ex2  = ex2_wr  && (ex2_dest  != 5'd0) && (ex2_dest  == src);
  assign hit_mem1 = !squash && mem1_wr && (mem1_dest != 5'd0) && (mem1_dest == src);
  assign hit_mem2 = !squash && mem2_wr && (mem2_dest != 5'd0) && (mem2_dest == src);

  // Ordered oldest to youngest so the youngest hit overrides.
  always_comb begin
    sel = FWD_RF;
    if (hit_mem1) sel = FWD_MEM1;
    if (hit_mem2) sel = FWD_MEM2;
    if (hit_ex1)  sel = FWD_EX1;
    if (hit_ex2)  sel = FWD_EX2;
  end

endmodule

// File: rtl/dual_mem_wb_pipe.sv
// rtl/dual_mem_wb_pipe.sv - MEM stage, MEM/WB registers and branch resolution
//
// Purpose: back half of the dual-issue not-taken pipeline. Performs data
// memory access for both slots, resolves mispredicted branches, holds the
// MEM/WB registers and returns forwarding/redirect information.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - dual_mem_wb_pipe_if.slave (MEM bundles in, WB/forward/redirect out)
module dual_mem_wb_pipe
  import dual_pipe_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024,
  parameter int PC_W       = dual_pipe_pkg::PC_W
)(
  input  logic               clk,
  input  logic               rst,
  dual_mem_wb_pipe_if.slave  bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic          squash_q;
  logic          live1, live2;
  logic          redir1, redir2, redir;
  logic          we1, we2;
  logic [AW-1:0] addr1, addr2;
  logic [31:0]   rd1, rd2;
  logic [31:0]   result1, result2;
  logic [31:0]   mem [DMEM_DEPTH];

  // ---------------- liveness and redirect ----------------
  // A taken slot1 branch kills its bundle partner; squash_q kills the
  // wrong-path bundle that was in EX during the redirect.
  assign live1  = !squash_q;
  assign live2  = !squash_q && !bus.taken1_MEM;
  assign redir1 = live1 && bus.taken1_MEM;
  assign redir2 = live2 && bus.taken2_MEM;
  assign redir  = redir1 | redir2;

  assign bus.correct_en = redir;
  assign bus.flush_IFID = redir;
  assign bus.flush_IDEX = redir;
  assign bus.correction = redir1 ? bus.branch_target1_MEM :
                          redir2 ? bus.branch_target2_MEM : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) squash_q <= 1'b0;
    else     squash_q <= redir;
  end

  // ---------------- data memory ----------------
  assign addr1 = bus.aluRes1_MEM[AW-1:0];
  assign addr2 = bus.aluRes2_MEM[AW-1:0];
  assign we1   = bus.MemWriteEn1_MEM && live1;
  assign we2   = bus.MemWriteEn2_MEM && live2;

  // Slot2 is younger, so it observes a same-cycle slot1 store; slot1 never
  // observes slot2's store.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.MemReadEn1_MEM) rd1 = mem[addr1];
    if (bus.MemReadEn2_MEM) rd2 = (we1 && (addr1 == addr2)) ? bus.forwardBRes1_MEM : mem[addr2];
  end

  // Slot2 write is issued last so it wins a same-word conflict.
  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= bus.forwardBRes1_MEM;
    if (we2) mem[addr2] <= bus.forwardBRes2_MEM;
  end

  // ---------------- slot results ----------------
  assign result1 = bus.jal1_MEM      ? {{(32-PC_W){1'b0}}, bus.return_addr1_MEM} :
                   bus.MemtoReg1_MEM ? rd1 : bus.aluRes1_MEM;
  assign result2 = bus.jal2_MEM      ? {{(32-PC_W){1'b0}}, bus.return_addr2_MEM} :
                   bus.MemtoReg2_MEM ? rd2 : bus.aluRes2_MEM;

  assign bus.aluRes1_MEM_fwd = result1;
  assign bus.aluRes2_MEM_fwd = result2;

  // ---------------- forwarding selects ----------------
  dual_fwd_unit u_fwd_a1 (
    .src(bus.rs1),
    .ex1_dest(bus.DestReg1_EX),   .ex1_wr(bus.RegWriteEn1_EX),
    .ex2_dest(bus.DestReg2_EX),   .ex2_wr(bus.RegWriteEn2_EX),
    .mem1_dest(bus.DestReg1_MEM), .mem1_wr(bus.RegWriteEn1_MEM),
    .mem2_dest(bus.DestReg2_MEM), .mem2_wr(bus.RegWriteEn2_MEM),
    .squash(squash_q), .sel(bus.ForwardA_1)
  );

  dual_fwd_unit u_fwd_b1 (
    .src(bus.rt1),
    .ex1_dest(bus.DestReg1_EX),   .ex1_wr(bus.RegWriteEn1_EX),
    .ex2_dest(bus.DestReg2_EX),   .ex2_wr(bus.RegWriteEn2_EX),
    .mem1_dest(bus.DestReg1_MEM), .mem1_wr(bus.RegWriteEn1_MEM),
    .mem2_dest(bus.DestReg2_MEM), .mem2_wr(bus.RegWriteEn2_MEM),
    .squash(squash_q), .sel(bus.ForwardB_1)
  );

  dual_fwd_unit u_fwd_a2 (
    .src(bus.rs2),
    .ex1_dest(bus.DestReg1_EX),   .ex1_wr(bus.RegWriteEn1_EX),
    .ex2_dest(bus.DestReg2_EX),   .ex2_wr(bus.RegWriteEn2_EX),
    .mem1_dest(bus.DestReg1_MEM), .mem1_wr(bus.RegWriteEn1_MEM),
    .mem2_dest(bus.DestReg2_MEM), .mem2_wr(bus.RegWriteEn2_MEM),
    .squash(squash_q), .sel(bus.ForwardA_2)
  );

  dual_fwd_unit u_fwd_b2 (
    .src(bus.rt2),
    .ex1_dest(bus.DestReg1_EX),   .ex1_wr(bus.RegWriteEn1_EX),
    .ex2_dest(bus.DestReg2_EX),   .ex2_wr(bus.RegWriteEn2_EX),
    .mem1_dest(bus.DestReg1_MEM), .mem1_wr(bus.RegWriteEn1_MEM),
    .mem2_dest(bus.DestReg2_MEM), .mem2_wr(bus.RegWriteEn2_MEM),
    .squash(squash_q), .sel(bus.ForwardB_2)
  );

  // ---------------- MEM/WB registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.regWrite1_WB  <= 1'b0;
      bus.regWrite2_WB  <= 1'b0;
      bus.jal1_WB       <= 1'b0;
      bus.jal2_WB       <= 1'b0;
      bus.writeReg1_WB  <= '0;
      bus.writeReg2_WB  <= '0;
      bus.writeData1_WB <= '0;
      bus.writeData2_WB <= '0;
      bus.aluRes1_WB    <= '0;
      bus.aluRes2_WB    <= '0;
    end else begin
      bus.regWrite1_WB  <= bus.RegWriteEn1_MEM && live1;
      bus.regWrite2_WB  <= bus.RegWriteEn2_MEM && live2;
      bus.jal1_WB       <= bus.jal1_MEM && live1;
      bus.jal2_WB       <= bus.jal2_MEM && live2;
      bus.writeReg1_WB  <= bus.DestReg1_MEM;
      bus.writeReg2_WB  <= bus.DestReg2_MEM;
      bus.writeData1_WB <= result1;
      bus.writeData2_WB <= result2;
      bus.aluRes1_WB    <= bus.aluRes1_MEM;
      bus.aluRes2_WB    <= bus.aluRes2_MEM;
    end
  end

endmodule

// File: tb/tb_dual_mem_wb_pipe.sv
// tb/tb_dual_mem_wb_pipe.sv - directed self-checking bench for dual_mem_wb_pipe
module tb_dual_mem_wb_pipe;
  import dual_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dual_mem_wb_pipe_if bus ();

  dual_mem_wb_pipe #(.DMEM_DEPTH(1024), .PC_W(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic idle();
    bus.aluRes1_MEM = '0;        bus.aluRes2_MEM = '0;
    bus.forwardBRes1_MEM = '0;   bus.forwardBRes2_MEM = '0;
    bus.MemReadEn1_MEM = 1'b0;   bus.MemReadEn2_MEM = 1'b0;
    bus.MemtoReg1_MEM = 1'b0;    bus.MemtoReg2_MEM = 1'b0;
    bus.MemWriteEn1_MEM = 1'b0;  bus.MemWriteEn2_MEM = 1'b0;
    bus.RegWriteEn1_MEM = 1'b0;  bus.RegWriteEn2_MEM = 1'b0;
    bus.jal1_MEM = 1'b0;         bus.jal2_MEM = 1'b0;
    bus.taken1_MEM = 1'b0;       bus.taken2_MEM = 1'b0;
    bus.DestReg1_MEM = '0;       bus.DestReg2_MEM = '0;
    bus.return_addr1_MEM = '0;   bus.return_addr2_MEM = '0;
    bus.branch_target1_MEM = '0; bus.branch_target2_MEM = '0;
    bus.rs1 = '0; bus.rt1 = '0; bus.rs2 = '0; bus.rt2 = '0;
    bus.DestReg1_EX = '0;        bus.DestReg2_EX = '0;
    bus.RegWriteEn1_EX = 1'b0;   bus.RegWriteEn2_EX = 1'b0;
  endtask

  // Advance one clock; returns 1 ns after the edge so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    if (bus.regWrite1_WB !== 1'b0) begin $display("FAIL reset_regWrite1: got %b want 0", bus.regWrite1_WB); n_bad++; end n_vec++;
    if (bus.writeData2_WB !== 32'h0) begin $display("FAIL reset_writeData2: got %h want 0", bus.writeData2_WB); n_bad++; end n_vec++;
    if (bus.correct_en !== 1'b0) begin $display("FAIL reset_correct_en: got %b want 0", bus.correct_en); n_bad++; end n_vec++;
    if (bus.ForwardA_1 !== 5'b00001) begin $display("FAIL reset_fwdA1: got %b want 00001", bus.ForwardA_1); n_bad++; end n_vec++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_forwarding();
    idle();
    bus.rs2 = 5'd5;
    bus.DestReg1_EX = 5'd5; bus.RegWriteEn1_EX = 1'b1;
    bus.DestReg2_EX = 5'd5; bus.RegWriteEn2_EX = 1'b1;
    #2;
    if (bus.ForwardA_2 !== 5'b00100) begin $display("FAIL fwd_ex2_prio: got %b want 00100", bus.ForwardA_2); n_bad++; end n_vec++;
    bus.rs2 = 5'd0; bus.DestReg1_EX = 5'd0; bus.DestReg2_EX = 5'd0;
    #2;
    if (bus.ForwardA_2 !== 5'b00001) begin $display("FAIL fwd_dest0: got %b want 00001", bus.ForwardA_2); n_bad++; end n_vec++;
    bus.rt1 = 5'd7; bus.DestReg1_EX = 5'd7; bus.RegWriteEn2_EX = 1'b0;
    bus.DestReg1_MEM = 5'd7; bus.RegWriteEn1_MEM = 1'b1;
    #2;
    if (bus.ForwardB_1 !== 5'b00010) begin $display("FAIL fwd_ex1_over_mem: got %b want 00010", bus.ForwardB_1); n_bad++; end n_vec++;
    bus.RegWriteEn1_EX = 1'b0;
    bus.DestReg2_MEM = 5'd7; bus.RegWriteEn2_MEM = 1'b1;
    #2;
    if (bus.ForwardB_1 !== 5'b10000) begin $display("FAIL fwd_mem2_prio: got %b want 10000", bus.ForwardB_1); n_bad++; end n_vec++;
    bus.RegWriteEn2_MEM = 1'b0;
    bus.rt2 = 5'd7;
    #2;
    if (bus.ForwardB_2 !== 5'b01000) begin $display("FAIL fwd_mem1: got %b want 01000", bus.ForwardB_2); n_bad++; end n_vec++;
    bus.RegWriteEn1_MEM = 1'b0;
    #2;
    if (bus.ForwardB_2 !== 5'b00001) begin $display("FAIL fwd_no_wr: got %b want 00001", bus.ForwardB_2); n_bad++; end n_vec++;
    step();
  endtask

  task automatic test_store_load_bypass();
    idle();
    bus.aluRes1_MEM = 32'd12; bus.forwardBRes1_MEM = 32'hDEADBEEF; bus.MemWriteEn1_MEM = 1'b1;
    bus.aluRes2_MEM = 32'd12; bus.MemReadEn2_MEM = 1'b1; bus.MemtoReg2_MEM = 1'b1;
    bus.RegWriteEn2_MEM = 1'b1; bus.DestReg2_MEM = 5'd3;
    #2;
    if (bus.aluRes2_MEM_fwd !== 32'hDEADBEEF) begin $display("FAIL bypass_fwd: got %h want deadbeef", bus.aluRes2_MEM_fwd); n_bad++; end n_vec++;
    step();
    if (bus.writeData2_WB !== 32'hDEADBEEF) begin $display("FAIL bypass_wb: got %h want deadbeef", bus.writeData2_WB); n_bad++; end n_vec++;
    if (bus.regWrite2_WB !== 1'b1) begin $display("FAIL bypass_regWrite2: got %b want 1", bus.regWrite2_WB); n_bad++; end n_vec++;
    if (bus.writeReg2_WB !== 5'd3) begin $display("FAIL bypass_writeReg2: got %0d want 3", bus.writeReg2_WB); n_bad++; end n_vec++;
    if (bus.aluRes2_WB !== 32'd12) begin $display("FAIL bypass_aluRes2: got %h want c", bus.aluRes2_WB); n_bad++; end n_vec++;
    idle();
    bus.aluRes1_MEM = 32'd12; bus.MemReadEn1_MEM = 1'b1; bus.MemtoReg1_MEM = 1'b1;
    #2;
    if (bus.aluRes1_MEM_fwd !== 32'hDEADBEEF) begin $display("FAIL mem12_readback: got %h want deadbeef", bus.aluRes1_MEM_fwd); n_bad++; end n_vec++;
    step();
  endtask

  task automatic test_dual_store();
    idle();
    bus.aluRes1_MEM = 32'd7; bus.forwardBRes1_MEM = 32'd1; bus.MemWriteEn1_MEM = 1'b1;
    bus.aluRes2_MEM = 32'd7; bus.forwardBRes2_MEM = 32'd2; bus.MemWriteEn2_MEM = 1'b1;
    step();
    idle();
    bus.aluRes1_MEM = 32'd8; bus.forwardBRes1_MEM = 32'h11; bus.MemWriteEn1_MEM = 1'b1;
    bus.aluRes2_MEM = 32'd7; bus.MemReadEn2_MEM = 1'b1; bus.MemtoReg2_MEM = 1'b1;
    #2;
    if (bus.aluRes2_MEM_fwd !== 32'd2) begin $display("FAIL dual_store_mem7: got %h want 2", bus.aluRes2_MEM_fwd); n_bad++; end n_vec++;
    step();
    // slot1 loads word 8 while slot2 stores to it: slot1 sees the old value
    idle();
    bus.aluRes1_MEM = 32'd8; bus.MemReadEn1_MEM = 1'b1; bus.MemtoReg1_MEM = 1'b1;
    bus.aluRes2_MEM = 32'd8; bus.forwardBRes2_MEM = 32'hAB; bus.MemWriteEn2_MEM = 1'b1;
    #2;
    if (bus.aluRes1_MEM_fwd !== 32'h11) begin $display("FAIL slot1_no_bypass: got %h want 11", bus.aluRes1_MEM_fwd); n_bad++; end n_vec++;
    step();
    idle();
    bus.aluRes1_MEM = 32'd8; bus.MemReadEn1_MEM = 1'b1; bus.MemtoReg1_MEM = 1'b1;
    #2;
    if (bus.aluRes1_MEM_fwd !== 32'hAB) begin $display("FAIL slot2_store_mem8: got %h want ab", bus.aluRes1_MEM_fwd); n_bad++; end n_vec++;
    step();
  endtask

  task automatic test_slot1_taken();
    idle();
    bus.aluRes1_MEM = 32'd20; bus.forwardBRes1_MEM = 32'h55; bus.MemWriteEn1_MEM = 1'b1;
    step();
    idle();
    bus.taken1_MEM = 1'b1; bus.branch_target1_MEM = 10'h3A;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = 5'd4; bus.aluRes1_MEM = 32'h77;
    bus.aluRes2_MEM = 32'd20; bus.forwardBRes2_MEM = 32'h99; bus.MemWriteEn2_MEM = 1'b1;
    bus.RegWriteEn2_MEM = 1'b1; bus.DestReg2_MEM = 5'd6;
    #2;
    if (bus.correct_en !== 1'b1) begin $display("FAIL t1_correct_en: got %b want 1", bus.correct_en); n_bad++; end n_vec++;
    if (bus.correction !== 10'h3A) begin $display("FAIL t1_correction: got %h want 3a", bus.correction); n_bad++; end n_vec++;
    if ({bus.flush_IFID, bus.flush_IDEX} !== 2'b11) begin $display("FAIL t1_flush: got %b want 11", {bus.flush_IFID, bus.flush_IDEX}); n_bad++; end n_vec++;
    step();
    if (bus.regWrite2_WB !== 1'b0) begin $display("FAIL t1_regWrite2_dead: got %b want 0", bus.regWrite2_WB); n_bad++; end n_vec++;
    if (bus.regWrite1_WB !== 1'b1) begin $display("FAIL t1_regWrite1_live: got %b want 1", bus.regWrite1_WB); n_bad++; end n_vec++;
    // wrong-path bundle: must not redirect, forward, store or write back
    idle();
    bus.taken1_MEM = 1'b1; bus.branch_target1_MEM = 10'h11;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = 5'd4; bus.rs1 = 5'd4;
    bus.aluRes1_MEM = 32'd20; bus.forwardBRes1_MEM = 32'h66; bus.MemWriteEn1_MEM = 1'b1;
    #2;
    if (bus.correct_en !== 1'b0) begin $display("FAIL squash_no_redirect: got %b want 0", bus.correct_en); n_bad++; end n_vec++;
    if (bus.correction !== 10'h0) begin $display("FAIL squash_correction: got %h want 0", bus.correction); n_bad++; end n_vec++;
    if (bus.flush_IFID !== 1'b0) begin $display("FAIL squash_flush: got %b want 0", bus.flush_IFID); n_bad++; end n_vec++;
    if (bus.ForwardA_1 !== 5'b00001) begin $display("FAIL squash_fwd: got %b want 00001", bus.ForwardA_1); n_bad++; end n_vec++;
    step();
    if (bus.regWrite1_WB !== 1'b0) begin $display("FAIL squash_regWrite1: got %b want 0", bus.regWrite1_WB); n_bad++; end n_vec++;
    idle();
    bus.aluRes1_MEM = 32'd20; bus.MemReadEn1_MEM = 1'b1; bus.MemtoReg1_MEM = 1'b1;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = 5'd2;
    #2;
    if (bus.aluRes1_MEM_fwd !== 32'h55) begin $display("FAIL t1_mem20_kept: got %h want 55", bus.aluRes1_MEM_fwd); n_bad++; end n_vec++;
    step();
    if (bus.regWrite1_WB !== 1'b1) begin $display("FAIL after_squash_wb: got %b want 1", bus.regWrite1_WB); n_bad++; end n_vec++;
    if (bus.writeData1_WB !== 32'h55) begin $display("FAIL after_squash_data: got %h want 55", bus.writeData1_WB); n_bad++; end n_vec++;
  endtask

  task automatic test_taken2_and_both();
    idle();
    bus.taken2_MEM = 1'b1; bus.branch_target2_MEM = 10'h2C;
    bus.RegWriteEn2_MEM = 1'b1; bus.DestReg2_MEM = 5'd6;
    #2;
    if (bus.correction !== 10'h2C) begin $display("FAIL t2_correction: got %h want 2c", bus.correction); n_bad++; end n_vec++;
    step();
    if (bus.regWrite2_WB !== 1'b1) begin $display("FAIL t2_regWrite2: got %b want 1", bus.regWrite2_WB); n_bad++; end n_vec++;
    idle();
    step();
    bus.taken1_MEM = 1'b1; bus.branch_target1_MEM = 10'h3A;
    bus.taken2_MEM = 1'b1; bus.branch_target2_MEM = 10'h2C; bus.RegWriteEn2_MEM = 1'b1;
    #2;
    if (bus.correction !== 10'h3A) begin $display("FAIL both_taken_correction: got %h want 3a", bus.correction); n_bad++; end n_vec++;
    step();
    if (bus.regWrite2_WB !== 1'b0) begin $display("FAIL both_taken_slot2_dead: got %b want 0", bus.regWrite2_WB); n_bad++; end n_vec++;
    idle();
    step();
  endtask

  task automatic test_jal();
    idle();
    bus.jal1_MEM = 1'b1; bus.return_addr1_MEM = 10'h104; bus.aluRes1_MEM = 32'h5555;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = RA_REG;
    #2;
    if (bus.aluRes1_MEM_fwd !== 32'h104) begin $display("FAIL jal_fwd: got %h want 104", bus.aluRes1_MEM_fwd); n_bad++; end n_vec++;
    step();
    if (bus.writeData1_WB !== 32'h104) begin $display("FAIL jal_writeData1: got %h want 104", bus.writeData1_WB); n_bad++; end n_vec++;
    if (bus.jal1_WB !== 1'b1) begin $display("FAIL jal1_WB: got %b want 1", bus.jal1_WB); n_bad++; end n_vec++;
    if (bus.aluRes1_WB !== 32'h5555) begin $display("FAIL jal_aluRes1_WB: got %h want 5555", bus.aluRes1_WB); n_bad++; end n_vec++;
    if (bus.writeReg1_WB !== 5'd31) begin $display("FAIL jal_writeReg1: got %0d want 31", bus.writeReg1_WB); n_bad++; end n_vec++;
    idle();
    step();
  endtask

  task automatic test_reset_mid_redirect();
    idle();
    bus.taken1_MEM = 1'b1; bus.branch_target1_MEM = 10'h3A;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = 5'd9;
    step();
    rst = 1'b1;
    #2;
    if (bus.regWrite1_WB !== 1'b0) begin $display("FAIL rst_mid_wb: got %b want 0", bus.regWrite1_WB); n_bad++; end n_vec++;
    rst = 1'b0;
    idle();
    bus.taken1_MEM = 1'b1; bus.branch_target1_MEM = 10'h40;
    bus.RegWriteEn1_MEM = 1'b1; bus.DestReg1_MEM = 5'd9; bus.aluRes1_MEM = 32'h1234;
    #1;
    if (bus.correct_en !== 1'b1) begin $display("FAIL rst_mid_redirect: got %b want 1", bus.correct_en); n_bad++; end n_vec++;
    if (bus.correction !== 10'h40) begin $display("FAIL rst_mid_correction: got %h want 40", bus.correction); n_bad++; end n_vec++;
    step();
    if (bus.regWrite1_WB !== 1'b1) begin $display("FAIL rst_mid_next_wb: got %b want 1", bus.regWrite1_WB); n_bad++; end n_vec++;
    if (bus.writeData1_WB !== 32'h1234) begin $display("FAIL rst_mid_next_data: got %h want 1234", bus.writeData1_WB); n_bad++; end n_vec++;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_store_load_bypass();
    test_dual_store();
    test_slot1_taken();
    test_taken2_and_both();
    test_jal();
    test_reset_mid_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
